// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: refill FSM states and the downstream beat width.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER
    } refill_state_t;

    localparam int MEM_BEAT_W = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Scan from the farthest offset down so the nearest requester overwrites earlier hits.
    always_comb begin
        grant = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                grant = '0;
                grant[(int'(ptr) + off) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shared L1 refill port: round-robin picks a missing cache, issues one line request,
// and streams the returned beats back with line-relative index and last marking.
module mem_refill_arbiter
    import mem_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int LINE_BYTES = 64,
    parameter int WRAP_FIRST = 1,
    localparam int BEATS     = LINE_BYTES / 8,
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [N_REQ*32-1:0]   req_addr_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic                  mem_req_valid_o,
    output logic [31:0]           mem_req_addr_o,
    output logic [BEAT_W-1:0]     mem_req_beat_o,
    input  logic                  mem_req_ready_i,
    input  logic                  mem_rsp_valid_i,
    input  logic [MEM_BEAT_W-1:0] mem_rsp_data_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [MEM_BEAT_W-1:0] rsp_data_o,
    output logic [BEAT_W-1:0]     rsp_beat_o,
    output logic                  rsp_last_o
);

    localparam logic [BEAT_W-1:0] LAST_CNT  = BEAT_W'(BEATS - 1);
    localparam logic [31:0]       LINE_MASK = ~32'(LINE_BYTES - 1);

    refill_state_t state_q, state_d;

    logic [ID_W-1:0]       rr_ptr_q, req_id_q, win_id;
    logic [BEAT_W-1:0]     start_q, cnt_q, win_start;
    logic [31:0]           line_q, win_addr;
    logic [N_REQ-1:0]      grant;
    logic                  accept, issue_done, beat_cap, stray_rsp;

    logic [N_REQ-1:0]      vld_p1;
    logic [MEM_BEAT_W-1:0] rsp_data_p1;
    logic [BEAT_W-1:0]     rsp_beat_p1;
    logic                  rsp_last_p1;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_id = ID_W'(i);
        end
    end

    assign win_addr  = req_addr_i[32*int'(win_id) +: 32];
    assign win_start = (WRAP_FIRST != 0 && BEATS > 1) ? BEAT_W'(win_addr >> 3) : '0;

    // Grants are masked while reset is asserted so every output reads zero immediately.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        issue_done  = 1'b0;
        beat_cap    = 1'b0;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if ((|grant) && reset_i) begin
                    accept      = 1'b1;
                    req_ready_o = grant;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    issue_done = 1'b1;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (mem_rsp_valid_i) begin
                    beat_cap = 1'b1;
                    if (cnt_q == LAST_CNT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            req_id_q <= '0;
            line_q   <= '0;
            start_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_id_q <= win_id;
                line_q   <= win_addr & LINE_MASK;
                start_q  <= win_start;
                rr_ptr_q <= (int'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
            end
            if (issue_done) begin
                cnt_q <= '0;
            end else if (beat_cap) begin
                cnt_q <= cnt_q + BEAT_W'(1);
            end
        end
    end

    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_req_addr_o  = line_q;
    assign mem_req_beat_o  = start_q;

    // Stage p1: captured memory beat, presented one cycle after it arrives.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_p1      <= '0;
            rsp_data_p1 <= '0;
            rsp_beat_p1 <= '0;
            rsp_last_p1 <= 1'b0;
        end else begin
            vld_p1      <= beat_cap ? (N_REQ'(1) << req_id_q) : '0;
            rsp_last_p1 <= beat_cap && (cnt_q == LAST_CNT);
            if (beat_cap) begin
                rsp_data_p1 <= mem_rsp_data_i;
                rsp_beat_p1 <= start_q + cnt_q;
            end
        end
    end

    assign rsp_valid_o = vld_p1;
    assign rsp_data_o  = rsp_data_p1;
    assign rsp_beat_o  = rsp_beat_p1;
    assign rsp_last_o  = rsp_last_p1;

    assign stray_rsp = reset_i && mem_rsp_valid_i && (state_q != XFER);

    always @(posedge clk_i) begin
        assert (!stray_rsp) else $warning("mem_rsp_valid_i seen outside XFER, beat dropped");
    end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shared refill port that lets several L1 caches (instruction cache, and the data cache that replaces the flat data memory) fetch full lines from one main-memory / L2 model. Each requester presents a miss address. A round-robin arbiter picks one. The block issues a single line request downstream, then streams the returned 64-bit beats back to the winner with beat index and last-beat marking. Optional critical-word-first wrapping is supported. It sits in the top level between the L1 caches and the memory model.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesting caches; index 0 is the instruction cache. Legal range 1–8.
- `LINE_BYTES`, default 64: cache line size. Must be a power of two, at least 8. `BEATS = LINE_BYTES/8`.
- `WRAP_FIRST`, default 1: 1 starts the burst at the missed word and wraps; 0 always starts at beat 0.

Ports:
- `clk_i` input 1: clock; all state changes on the rising edge.
- `reset_i` input 1: asynchronous, active-low reset.
- `req_valid_i` input `N_REQ`: per-requester miss request.
- `req_addr_i` input `N_REQ*32`: miss byte addresses; requester i uses bits `[32i+31:32i]`.
- `req_ready_o` output `N_REQ`: one-hot request accept.
- `mem_req_valid_o` output 1: line request to memory.
- `mem_req_addr_o` output 32: line-aligned address (low `log2(LINE_BYTES)` bits zero).
- `mem_req_beat_o` output `log2(BEATS)`: first beat memory must return.
- `mem_req_ready_i` input 1: memory accepts the request.
- `mem_rsp_valid_i` input 1: one data beat returned.
- `mem_rsp_data_i` input 64: beat data.
- `rsp_valid_o` output `N_REQ`: one-hot beat strobe to the granted requester.
- `rsp_data_o` output 64: beat data, shared by all requesters.
- `rsp_beat_o` output `log2(BEATS)`: line-relative index of the beat.
- `rsp_last_o` output 1: final beat of the line.

## Operation
- States:
  - IDLE: accept a request.
  - ISSUE: hold the memory request.
  - XFER: stream beats.
- **IDLE**
  - Arbiter is combinational round-robin from pointer `rr_ptr`: the first `i ≥ rr_ptr` (wrapping) with `req_valid_i[i]` wins.
  - `req_ready_o[i]` is high only for the winner, and only in IDLE.
  - On handshake: latch the requester id and address, set `rr_ptr = (i+1) mod N_REQ`, move to ISSUE.
- **ISSUE**
  - `mem_req_valid_o=1`, with address and start beat coming from registers.
  - Hold values stable until `mem_req_ready_i`; then move to XFER with beat counter 0.
- **XFER**
  - Each `mem_rsp_valid_i` beat is registered and presented one cycle later.
  - `rsp_beat_o = (start + count) mod BEATS`; `rsp_last_o` is high when `count == BEATS-1`.
  - After the last beat is captured, the state returns to IDLE.
- Start beat: `addr[log2(LINE_BYTES)-1:3]` if `WRAP_FIRST`, else 0.
- After a request is accepted, the requester's `req_valid_i` and address are ignored until its transfer completes.
- A requester may drop `req_valid_i` before acceptance; nothing is recorded for it.
- `mem_rsp_valid_i` outside XFER is ignored, and a simulation-only assertion fires.
- There is no backpressure on the response side; requesters must sink one beat per cycle.
- `N_REQ=1`: arbitration degenerates; `rr_ptr` stays 0.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `rr_ptr=0`, counter 0.
  - All outputs 0: `req_ready_o`, `mem_req_*`, `rsp_valid_o`, `rsp_data_o`, `rsp_beat_o`, `rsp_last_o`.
  - Reset mid-burst abandons the transfer; no partial `rsp_last_o` is produced.
- Request accept: the same cycle as `req_valid_i` in IDLE. `mem_req_valid_o` rises the next cycle.
- Memory beat in cycle t gives `rsp_valid_o` in cycle t+1.
- The cycle with `rsp_last_o` high is already IDLE, so a new request may be accepted in that cycle (back-to-back lines).
- Minimum line service time is `BEATS+2` cycles from accept to last beat when memory responds immediately.
- Simultaneous requests: exactly one `req_ready_o` bit is high. Losers keep `req_valid_i` asserted and are served in rotation.

## Structure
- Shared package `mem_pkg`:
  - `refill_state_t` enum {IDLE, ISSUE, XFER};
  - beat width constant `MEM_BEAT_W=64`.
- One sub-module `rr_arbiter` (parameter `N`): inputs are request vector and pointer; output is one-hot grant. It is reusable for future write-back arbitration.
- Everything else (FSM, latches, beat counter, response register) lives in `mem_refill_arbiter`.

## Test plan
- Reset, then `req_valid_i=01`, addr `0x0000_1238`, `WRAP_FIRST=1`:
  - `mem_req_addr_o=0x0000_1200`, `mem_req_beat_o=7`;
  - 8 beats return with `rsp_beat_o` 7,0,1,…,6;
  - `rsp_last_o` on the 8th beat; only `rsp_valid_o[0]` toggles.
- Same stimulus with `WRAP_FIRST=0`: `mem_req_beat_o=0`, beats 0..7.
- `req_valid_i=11` held continuously: grants alternate 0,1,0,1 over four lines, and each new accept coincides with the previous `rsp_last_o`.
- `mem_req_ready_i` held low 5 cycles: `mem_req_valid_o` and address stay stable; no `req_ready_o` during the stall.
- Assert `reset_i=0` on beat 3 of a burst: all outputs are 0 immediately. After release, a request from requester 1 is accepted normally, and `rr_ptr` restarts at 0.
- Stray `mem_rsp_valid_i` in IDLE: no `rsp_valid_o`, and the assertion flags it.
